// File: rtl/spi_output_controller_dac.sv
// SPI transmitter for an 8-bit serial DAC (16-bit frame, MSB first, SCLK idle high).
// Optional macro SPI_DAC_HOLD_EN adds a one-entry sample holding register.
module spi_output_controller_dac #(
    parameter int CLK_DIV   = 25,
    parameter int GAP_TICKS = 2
) (
    input  logic       clock_50Mhz,
    input  logic       reset_n,
    output logic       output_SPI_SCLK,
    output logic       output_SPI_SYNC_n,
    output logic       output_SPI_DIN,
    input  logic [7:0] inputSample,
    input  logic [1:0] powerDownMode,
    input  logic       sendSample,
    output logic       readyForSample,
    output logic       sampleDone
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TW = (GAP_TICKS > 32) ? $clog2(GAP_TICKS + 1) : 6;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [TW-1:0] T_END    = TW'(32);
    localparam logic [TW-1:0] T_GAP    = TW'(GAP_TICKS);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t        state, state_n;
    logic [DW-1:0] div, div_n;
    logic [TW-1:0] tcnt, tcnt_n, tn;
    logic [15:0]   shreg, shreg_n;
    logic          sclk, sclk_n;
    logic          sync, sync_n;
    logic          din, din_n;
    logic          done, done_n;
    logic          tick;
    logic          load;
    logic [15:0]   load_word;
    logic [15:0]   frame_in;

`ifdef SPI_DAC_HOLD_EN
    logic          hold_full, hold_full_n;
    logic [15:0]   hold_word, hold_word_n;
`endif

    assign frame_in = {2'b00, powerDownMode, inputSample, 4'b0000};
    assign tick     = (state != IDLE) && (div == DIV_LAST);
    assign tn       = tcnt + TW'(1);

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            div   <= '0;
            tcnt  <= '0;
            shreg <= '0;
            sclk  <= 1'b1;
            sync  <= 1'b1;
            din   <= 1'b0;
            done  <= 1'b0;
`ifdef SPI_DAC_HOLD_EN
            hold_full <= 1'b0;
            hold_word <= '0;
`endif
        end else begin
            state <= state_n;
            div   <= div_n;
            tcnt  <= tcnt_n;
            shreg <= shreg_n;
            sclk  <= sclk_n;
            sync  <= sync_n;
            din   <= din_n;
            done  <= done_n;
`ifdef SPI_DAC_HOLD_EN
            hold_full <= hold_full_n;
            hold_word <= hold_word_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        div_n     = div;
        tcnt_n    = tcnt;
        shreg_n   = shreg;
        sclk_n    = sclk;
        sync_n    = sync;
        din_n     = din;
        done_n    = 1'b0;
        load      = 1'b0;
        load_word = frame_in;
`ifdef SPI_DAC_HOLD_EN
        hold_full_n = hold_full;
        hold_word_n = hold_word;
`endif
        if (state != IDLE) begin
            div_n = tick ? '0 : div + DW'(1);
        end
        unique case (state)
            IDLE: begin
                if (sendSample) begin
                    load = 1'b1;
                end
            end
            SHIFT: begin
                if (tick) begin
                    tcnt_n = tn;
                    if (tn == T_END) begin
                        sclk_n  = 1'b1;
                        sync_n  = 1'b1;
                        din_n   = 1'b0;
                        done_n  = 1'b1;
                        tcnt_n  = '0;
                        state_n = GAP;
                    end else if (tn[0]) begin
                        sclk_n = 1'b0;
                    end else begin
                        sclk_n  = 1'b1;
                        shreg_n = {shreg[14:0], 1'b0};
                        din_n   = shreg[14];
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    tcnt_n = tn;
                    if (tn == T_GAP) begin
                        tcnt_n  = '0;
                        state_n = IDLE;
`ifdef SPI_DAC_HOLD_EN
                        // chain straight into the next frame without an IDLE cycle
                        if (hold_full) begin
                            load        = 1'b1;
                            load_word   = hold_word;
                            hold_full_n = 1'b0;
                        end else if (sendSample) begin
                            load = 1'b1;
                        end
`endif
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (load) begin
            state_n = SHIFT;
            shreg_n = load_word;
            sync_n  = 1'b0;
            din_n   = load_word[15];
            sclk_n  = 1'b1;
            div_n   = '0;
            tcnt_n  = '0;
        end
`ifdef SPI_DAC_HOLD_EN
        if (sendSample && !hold_full && state != IDLE && !load) begin
            hold_full_n = 1'b1;
            hold_word_n = frame_in;
        end
`endif
    end

`ifdef SPI_DAC_HOLD_EN
    assign readyForSample = !hold_full;
`else
    assign readyForSample = (state == IDLE);
`endif

    assign output_SPI_SCLK   = sclk;
    assign output_SPI_SYNC_n = sync;
    assign output_SPI_DIN    = din;
    assign sampleDone        = done;

endmodule
